// File: rtl/spi_master_seq.sv
// rtl/spi_master_seq.sv - SPI master transfer sequencer: chip select, SCLK divider, MSB-first shift
// One start/done handshake per word; mode, divider and data are latched when the transfer starts.
module spi_master_seq #(
   parameter int DATA_W = 8,
   parameter int DIV_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_start,
   input  logic              i_cpol,
   input  logic              i_cpha,
   input  logic [DIV_W-1:0]  i_clk_div,
   input  logic [DATA_W-1:0] i_tx_data,
   input  logic              i_miso,
   output logic              o_sclk,
   output logic              o_mosi,
   output logic              o_cs_n,
   output logic              o_busy,
   output logic              o_done,
   output logic [DATA_W-1:0] o_rx_data
);

   localparam int EW = $clog2(2 * DATA_W + 1);
   localparam logic [EW-1:0]  LAST_EDGE = EW'(2 * DATA_W);
   localparam logic [EW-1:0]  EDGE_ONE  = {{(EW-1){1'b0}}, 1'b1};
   localparam logic [DIV_W:0] CNT_ONE   = {{DIV_W{1'b0}}, 1'b1};

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_DONE} state_t;

   state_t            r_state;
   logic [DIV_W:0]    r_cnt;
   logic [DIV_W-1:0]  r_div;
   logic [EW-1:0]     r_edge;
   logic [DATA_W-1:0] r_tx;
   logic [DATA_W-1:0] r_rx;
   logic              r_cpol;
   logic              r_cpha;

   logic              w_slot_end;
   logic              w_fire;
   logic              w_leading;
   logic [EW-1:0]     w_next_edge;

   // One slot is H = div+1 cycles; an SCLK edge fires at the start of every transfer slot.
   assign w_slot_end  = (r_cnt == {1'b0, r_div});
   assign w_next_edge = r_edge + EDGE_ONE;
   assign w_leading   = w_next_edge[0];
   assign w_fire      = w_slot_end &&
                        ((r_state == S_SETUP) || ((r_state == S_XFER) && (r_edge != LAST_EDGE)));

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_div     <= '0;
         r_edge    <= '0;
         r_tx      <= '0;
         r_rx      <= '0;
         r_cpol    <= 1'b0;
         r_cpha    <= 1'b0;
         o_sclk    <= i_cpol;
         o_mosi    <= 1'b0;
         o_cs_n    <= 1'b1;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_rx_data <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               o_sclk <= i_cpol;
               o_cs_n <= 1'b1;
               o_busy <= 1'b0;
               o_done <= 1'b0;
               o_mosi <= 1'b0;
               r_cnt  <= '0;
               r_edge <= '0;
               if (i_start) begin
                  r_cpol  <= i_cpol;
                  r_cpha  <= i_cpha;
                  r_div   <= i_clk_div;
                  r_tx    <= i_tx_data;
                  o_cs_n  <= 1'b0;
                  o_busy  <= 1'b1;
                  o_mosi  <= i_cpha ? 1'b0 : i_tx_data[DATA_W-1];
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (w_slot_end) begin
                  r_cnt   <= '0;
                  r_state <= S_XFER;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            S_XFER: begin
               if (w_slot_end) begin
                  r_cnt <= '0;
                  if (r_edge == LAST_EDGE) r_state <= S_HOLD;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            S_HOLD: begin
               o_sclk <= r_cpol;
               if (w_slot_end) begin
                  r_cnt     <= '0;
                  o_done    <= 1'b1;
                  o_cs_n    <= 1'b1;
                  o_mosi    <= 1'b0;
                  o_rx_data <= r_rx;
                  r_state   <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            S_DONE: begin
               o_done  <= 1'b0;
               o_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase

         // Odd edges lead; cpha picks whether leading edges sample or launch the next bit.
         if (w_fire) begin
            r_edge <= w_next_edge;
            o_sclk <= ~o_sclk;
            if (w_leading) begin
               if (r_cpha) begin
                  o_mosi <= r_tx[DATA_W-1];
                  r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
               end else begin
                  r_rx <= {r_rx[DATA_W-2:0], i_miso};
               end
            end else begin
               if (r_cpha) begin
                  r_rx <= {r_rx[DATA_W-2:0], i_miso};
               end else if (w_next_edge != LAST_EDGE) begin
                  o_mosi <= r_tx[DATA_W-2];
                  r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
               end
            end
         end
      end
   end

endmodule
